mem_stage_ctrl: RTL and testbench

- Parametrised memory-stage controller between the execute/memory pipeline register and the data cache (`mem_system` interface: Rd/Wr/Done/Stall/err).
- Adds capabilities the single-cycle wrapper lacks:
  - a request FSM that holds cache requests until Done;
  - byte loads with sign/zero extension;
  - byte stores via read-modify-write;
  - result holding under external pipeline stalls;
  - a watchdog timeout.
- Produces `dc_stall` to freeze earlier stages and `mem_out` for write-back.

---
 rtl/mem_stage_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 511 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
//
// Memory-stage controller that sits between the execute/memory pipeline
// register and the data cache. It holds each cache request until the cache
// signals c_done. It provides byte loads with sign or zero extension, and byte
// stores done as a read-modify-write of the containing word. It keeps the load
// result stable while the pipeline is frozen by another stage. A watchdog
// abandons cache operations that never complete.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   addr, wdata   : byte address and store data from the execute stage
//   mem_read      : load request
//   mem_write     : store request
//   byte_op       : access is one byte (addr[0] = 1 selects the high byte)
//   sign_ext      : sign-extend (1) or zero-extend (0) a byte load
//   hold          : another stage froze the pipeline this cycle
//   createdump    : forwarded to the cache unchanged
//   mem_out       : load result for write-back
//   dc_stall      : memory stage busy, earlier stages must freeze
//   err           : misaligned request, or sticky cache/timeout error
//   c_addr/c_din/c_rd/c_wr/c_createdump : request side of the cache
//   c_dout/c_done/c_stall/c_err          : response side of the cache
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int BYTE_EN = 1,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              byte_op,
  input  logic              sign_ext,
  input  logic              hold,
  input  logic              createdump,
  output logic [DATA_W-1:0] mem_out,
  output logic              dc_stall,
  output logic              err,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_din,
  output logic              c_rd,
  output logic              c_wr,
  output logic              c_createdump,
  input  logic [DATA_W-1:0] c_dout,
  input  logic              c_done,
  input  logic              c_stall,
  input  logic              c_err
);

  // Watchdog counter is wide enough to hold TIMEOUT itself.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_HOLD
  } state_t;

  state_t            state_reg;
  logic [DATA_W-1:0] mem_out_reg;
  logic              err_reg;
  logic [CNT_W-1:0]  wait_cnt_reg;
  logic [DATA_W-1:0] rmw_buf_reg;

  // Request fields captured at acceptance, so the cache sees a stable
  // request for the whole transaction.
  logic [ADDR_W-1:0] addr_reg;
  logic              addr0_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              byte_reg;
  logic              sign_reg;
  logic              load_reg;

  // ---------------------------------------------------------------------------
  // Request classification
  // ---------------------------------------------------------------------------
  logic req;
  logic eff_byte;
  logic misalign;
  logic valid_req;

  assign req       = mem_read | mem_write;
  // With byte support compiled out, a byte request is a word request.
  assign eff_byte  = (BYTE_EN != 0) && byte_op;
  // A simultaneous read and write has no meaning, so it is flagged like a
  // misaligned access.
  assign misalign  = req && ((mem_read && mem_write) || (!eff_byte && addr[0]));
  assign valid_req = req && !misalign;

  // ---------------------------------------------------------------------------
  // Wait-state bookkeeping
  // ---------------------------------------------------------------------------
  logic in_wait;
  logic timeout_hit;
  logic done_ok;
  logic complete;

  always_comb begin
    in_wait = 1'b0;
    case (state_reg)
      S_RD, S_WR, S_RMW_RD, S_RMW_WR: in_wait = 1'b1;
      default:                        in_wait = 1'b0;
    endcase
  end

  // In the timeout cycle the request is already dropped, so a late c_done
  // there is not taken as the cache's answer.
  assign timeout_hit = (TIMEOUT != 0) && in_wait && (wait_cnt_reg == TO_VAL);
  assign done_ok     = in_wait && c_done && !timeout_hit;
  // The read half of a read-modify-write never ends the instruction.
  assign complete    = timeout_hit || (done_ok && (state_reg != S_RMW_RD));

  // ---------------------------------------------------------------------------
  // Load formatting and store merge
  // ---------------------------------------------------------------------------
  logic [7:0]        sel_byte;
  logic [DATA_W-1:0] load_fmt;
  logic [DATA_W-1:0] rmw_merged;

  // addr[0] picks the byte lane within the 16-bit halfword at c_addr.
  assign sel_byte = addr0_reg ? c_dout[15:8] : c_dout[7:0];

  always_comb begin
    load_fmt = c_dout;
    if (byte_reg) begin
      load_fmt = {{(DATA_W-8){sign_reg & sel_byte[7]}}, sel_byte};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign rmw_merged[gi*8 +: 8] = (addr0_reg == (gi == 1)) ? wdata_reg[7:0]
                                                              : rmw_buf_reg[gi*8 +: 8];
    end
    if (DATA_W > 16) begin : g_upper
      assign rmw_merged[DATA_W-1:16] = rmw_buf_reg[DATA_W-1:16];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs. Reset blanks the requests and the stall in the same cycle, which
  // abandons any in-flight cache operation.
  // ---------------------------------------------------------------------------
  always_comb begin
    c_rd     = 1'b0;
    c_wr     = 1'b0;
    dc_stall = 1'b0;
    err      = 1'b0;
    mem_out  = mem_out_reg;
    c_addr   = addr_reg;
    c_din    = wdata_reg;

    if (state_reg == S_IDLE) begin
      c_addr = {addr[ADDR_W-1:1], 1'b0};
    end
    if (state_reg == S_RMW_WR) begin
      c_din = rmw_merged;
    end

    if (!rst) begin
      c_rd     = ((state_reg == S_RD) || (state_reg == S_RMW_RD)) && !timeout_hit;
      c_wr     = ((state_reg == S_WR) || (state_reg == S_RMW_WR)) && !timeout_hit;
      dc_stall = ((state_reg == S_IDLE) && valid_req) || (in_wait && !complete);
      err      = ((state_reg == S_IDLE) && misalign) || err_reg;
      // The completion cycle forwards the fresh load data directly. A store or
      // a timeout leaves the previous result in place.
      if (complete && load_reg && !timeout_hit) begin
        mem_out = load_fmt;
      end
    end
  end

  assign c_createdump = createdump;

  // The cache's busy flag is informational only; the FSM keys on c_done.
  logic unused_inputs;
  assign unused_inputs = c_stall;

  // ---------------------------------------------------------------------------
  // State and data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      mem_out_reg  <= '0;
      err_reg      <= 1'b0;
      wait_cnt_reg <= '0;
      rmw_buf_reg  <= '0;
      addr_reg     <= '0;
      addr0_reg    <= 1'b0;
      wdata_reg    <= '0;
      byte_reg     <= 1'b0;
      sign_reg     <= 1'b0;
      load_reg     <= 1'b0;
    end else begin
      if (c_err || timeout_hit) begin
        err_reg <= 1'b1;
      end

      case (state_reg)
        S_IDLE: begin
          if (valid_req) begin
            addr_reg     <= {addr[ADDR_W-1:1], 1'b0};
            addr0_reg    <= addr[0];
            wdata_reg    <= wdata;
            byte_reg     <= eff_byte;
            sign_reg     <= sign_ext;
            load_reg     <= mem_read;
            wait_cnt_reg <= '0;
            if (mem_read) begin
              state_reg <= S_RD;
            end else if (eff_byte) begin
              state_reg <= S_RMW_RD;
            end else begin
              state_reg <= S_WR;
            end
          end
        end

        S_RD, S_WR, S_RMW_RD, S_RMW_WR: begin
          if (complete) begin
            state_reg <= hold ? S_HOLD : S_IDLE;
            if (load_reg && !timeout_hit) begin
              mem_out_reg <= load_fmt;
            end
          end else if (done_ok) begin
            // Only the read half of a read-modify-write gets here.
            rmw_buf_reg  <= c_dout;
            wait_cnt_reg <= '0;
            state_reg    <= S_RMW_WR;
          end else if (TIMEOUT != 0) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end

        S_HOLD: begin
          // The frozen instruction has finished. It advances once the freeze
          // lifts and is not reissued.
          if (!hold) begin
            state_reg <= S_IDLE;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
//
// Self-checking bench for mem_stage_ctrl (16-bit data and address, byte ops
// enabled, TIMEOUT = 8). The bench models the data cache with a word array.
// It predicts load results, merged store words and the stall/request timing
// from the block's behavioural rules.
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic        byte_op;
  logic        sign_ext;
  logic        hold;
  logic        createdump;
  logic [15:0] mem_out;
  logic        dc_stall;
  logic        err;
  logic [15:0] c_addr;
  logic [15:0] c_din;
  logic        c_rd;
  logic        c_wr;
  logic        c_createdump;
  logic [15:0] c_dout;
  logic        c_done;
  logic        c_stall;
  logic        c_err;

  mem_stage_ctrl #(
    .DATA_W (16),
    .ADDR_W (16),
    .BYTE_EN(1),
    .TIMEOUT(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .wdata       (wdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .byte_op     (byte_op),
    .sign_ext    (sign_ext),
    .hold        (hold),
    .createdump  (createdump),
    .mem_out     (mem_out),
    .dc_stall    (dc_stall),
    .err         (err),
    .c_addr      (c_addr),
    .c_din       (c_din),
    .c_rd        (c_rd),
    .c_wr        (c_wr),
    .c_createdump(c_createdump),
    .c_dout      (c_dout),
    .c_done      (c_done),
    .c_stall     (c_stall),
    .c_err       (c_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: cache contents and the write-back value the stage
  // should be presenting.
  logic [15:0] mem [256];
  logic [15:0] model_out;
  logic [15:0] last_din;
  int          vectors;
  int          miscompares;
  int          opn;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One load or store, with the cache answering after `lat` waiting cycles.
  // The freeze is held for `hc` cycles counted from the completion cycle.
  // The task starts and ends on a falling edge.
  task automatic run_op(input bit rd, input bit byt, input bit sx,
                        input logic [15:0] a, input logic [15:0] wd,
                        input int lat, input int hc, input string tag);
    logic [15:0] word_a;
    logic [15:0] exp_din;
    logic [7:0]  b;
    int          phases;
    bit          last;
    bit          exp_rd;
    word_a    = {a[15:1], 1'b0};
    mem_read  = rd;
    mem_write = !rd;
    byte_op   = byt;
    sign_ext  = sx;
    addr      = a;
    wdata     = wd;
    c_done    = 1'b0;
    hold      = 1'b0;
    #1;
    vectors++;
    if (dc_stall !== 1'b1 || c_rd !== 1'b0 || c_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL %s accept: got stall=%b rd=%b wr=%b want stall=1 rd=0 wr=0",
               tag, dc_stall, c_rd, c_wr);
    end
    tick();
    phases = (!rd && byt) ? 2 : 1;
    for (int p = 0; p < phases; p++) begin
      last   = (p == phases - 1);
      exp_rd = rd || (p == 0 && phases == 2);
      if (phases == 2) begin
        exp_din = a[0] ? {wd[7:0], mem[a[8:1]][7:0]} : {mem[a[8:1]][15:8], wd[7:0]};
      end else begin
        exp_din = wd;
      end
      for (int n = 0; n <= lat; n++) begin
        c_done = (n == lat);
        c_dout = c_done ? mem[a[8:1]] : 16'($urandom);
        if (c_done && last && hc > 0) hold = 1'b1;
        #1;
        vectors++;
        if (c_rd !== exp_rd || c_wr !== !exp_rd) begin
          miscompares++;
          $display("FAIL %s req p%0d n%0d: got rd=%b wr=%b want rd=%b wr=%b",
                   tag, p, n, c_rd, c_wr, exp_rd, !exp_rd);
        end
        vectors++;
        if (c_addr !== word_a) begin
          miscompares++;
          $display("FAIL %s c_addr: got %h want %h", tag, c_addr, word_a);
        end
        if (!exp_rd) begin
          vectors++;
          if (c_din !== exp_din) begin
            miscompares++;
            $display("FAIL %s c_din: got %h want %h", tag, c_din, exp_din);
          end
        end
        if (c_done && last) begin
          if (rd) begin
            if (byt) begin
              b = a[0] ? mem[a[8:1]][15:8] : mem[a[8:1]][7:0];
              model_out = (sx && b >= 8'h80) ? (16'hFF00 | 16'(b)) : 16'(b);
            end else begin
              model_out = mem[a[8:1]];
            end
          end else begin
            last_din    = c_din;
            mem[a[8:1]] = exp_din;
          end
          vectors++;
          if (dc_stall !== 1'b0 || mem_out !== model_out) begin
            miscompares++;
            $display("FAIL %s complete: got stall=%b out=%h want stall=0 out=%h",
                     tag, dc_stall, mem_out, model_out);
          end
        end else begin
          vectors++;
          if (dc_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy p%0d n%0d: got stall=%b want 1", tag, p, n, dc_stall);
          end
        end
        tick();
      end
    end
    // Frozen after completion: nothing reissued, a stray c_done is ignored.
    for (int h = 1; h <= hc; h++) begin
      hold   = (h < hc);
      c_done = 1'b1;
      c_dout = 16'($urandom);
      #1;
      vectors++;
      if (c_rd !== 1'b0 || c_wr !== 1'b0 || dc_stall !== 1'b0 || mem_out !== model_out) begin
        miscompares++;
        $display("FAIL %s hold%0d: got rd=%b wr=%b stall=%b out=%h want 0 0 0 %h",
                 tag, h, c_rd, c_wr, dc_stall, mem_out, model_out);
      end
      tick();
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    hold      = 1'b0;
    c_done    = 1'b0;
    opn++;
    $display("op %0d %s rd=%b byte=%b sx=%b a=%h wd=%h lat=%0d hold=%0d mem_out=%h",
             opn, tag, rd, byt, sx, a, wd, lat, hc, model_out);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    mem_read = 1'b1;
    addr     = 16'h0010;
    #1;
    vectors++;
    if (dc_stall !== 1'b0 || c_rd !== 1'b0 || c_wr !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_during: got stall=%b rd=%b wr=%b err=%b want all 0",
               dc_stall, c_rd, c_wr, err);
    end
    tick();
    tick();
    mem_read = 1'b0;
    rst      = 1'b0;
    #1;
    vectors++;
    if (mem_out !== 16'h0000 || dc_stall !== 1'b0 || err !== 1'b0 || c_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_after: got out=%h stall=%b err=%b rd=%b want 0 0 0 0",
               mem_out, dc_stall, err, c_rd);
    end
    model_out = 16'h0000;
    tick();
  endtask

  task automatic test_word_load();
    mem[8'h08] = 16'hBEEF;
    run_op(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 3, 0, "word_load");
    #1;
    vectors++;
    if (mem_out !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL word_load_after: got %h want beef", mem_out);
    end
    tick();
  endtask

  task automatic test_byte_load();
    mem[8'h10] = 16'h80AB;
    run_op(1'b1, 1'b1, 1'b1, 16'h0021, 16'h0000, 1, 0, "byte_load_sx");
    #1;
    vectors++;
    if (mem_out !== 16'hFF80) begin
      miscompares++;
      $display("FAIL byte_load_sx: got %h want ff80", mem_out);
    end
    tick();
    run_op(1'b1, 1'b1, 1'b0, 16'h0021, 16'h0000, 2, 0, "byte_load_zx");
    #1;
    vectors++;
    if (mem_out !== 16'h0080) begin
      miscompares++;
      $display("FAIL byte_load_zx: got %h want 0080", mem_out);
    end
    tick();
  endtask

  task automatic test_byte_store();
    mem[8'h18] = 16'h1234;
    run_op(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0055, 1, 0, "byte_store_lo");
    vectors++;
    if (last_din !== 16'h1255) begin
      miscompares++;
      $display("FAIL byte_store_lo: got %h want 1255", last_din);
    end
    mem[8'h19] = 16'h3344;
    run_op(1'b0, 1'b1, 1'b0, 16'h0033, 16'hAA77, 0, 0, "byte_store_hi");
    vectors++;
    if (last_din !== 16'h7744) begin
      miscompares++;
      $display("FAIL byte_store_hi: got %h want 7744", last_din);
    end
  endtask

  task automatic test_misaligned();
    logic [15:0] a_tab [3];
    bit          rd_tab[3];
    bit          wr_tab[3];
    a_tab[0] = 16'h0003; rd_tab[0] = 1'b0; wr_tab[0] = 1'b1;
    a_tab[1] = 16'h0005; rd_tab[1] = 1'b1; wr_tab[1] = 1'b0;
    a_tab[2] = 16'h0010; rd_tab[2] = 1'b1; wr_tab[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr      = a_tab[i];
      mem_read  = rd_tab[i];
      mem_write = wr_tab[i];
      byte_op   = 1'b0;
      #1;
      vectors++;
      if (err !== 1'b1 || c_rd !== 1'b0 || c_wr !== 1'b0 || dc_stall !== 1'b0) begin
        miscompares++;
        $display("FAIL misalign%0d: got err=%b rd=%b wr=%b stall=%b want 1 0 0 0",
                 i, err, c_rd, c_wr, dc_stall);
      end
      tick();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      #1;
      vectors++;
      if (err !== 1'b0 || dc_stall !== 1'b0 || c_rd !== 1'b0 || c_wr !== 1'b0) begin
        miscompares++;
        $display("FAIL misalign%0d_after: got err=%b stall=%b rd=%b wr=%b want 0 0 0 0",
                 i, err, dc_stall, c_rd, c_wr);
      end
      tick();
      $display("op misaligned %0d a=%h rd=%b wr=%b", i, a_tab[i], rd_tab[i], wr_tab[i]);
    end
  endtask

  task automatic test_hold();
    mem[8'h20] = 16'h5A5A;
    run_op(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 2, 3, "hold_load");
    #1;
    vectors++;
    if (c_rd !== 1'b0 || dc_stall !== 1'b0 || mem_out !== 16'h5A5A) begin
      miscompares++;
      $display("FAIL hold_exit: got rd=%b stall=%b out=%h want 0 0 5a5a",
               c_rd, dc_stall, mem_out);
    end
    tick();
    run_op(1'b0, 1'b1, 1'b0, 16'h0041, 16'h00C3, 1, 2, "hold_rmw");
  endtask

  task automatic test_back_to_back();
    run_op(1'b0, 1'b0, 1'b0, 16'h0060, 16'hCAFE, 0, 0, "b2b_store");
    run_op(1'b1, 1'b0, 1'b0, 16'h0060, 16'h0000, 0, 0, "b2b_load");
    run_op(1'b1, 1'b1, 1'b1, 16'h0061, 16'h0000, 0, 0, "b2b_byte");
    vectors++;
    if (model_out !== 16'hFFCA || mem_out !== 16'hFFCA) begin
      miscompares++;
      $display("FAIL b2b_result: got %h want ffca", mem_out);
    end
  endtask

  task automatic test_random();
    bit          rd;
    bit          byt;
    logic [15:0] a;
    for (int i = 0; i < 60; i++) begin
      rd  = 1'($urandom_range(0, 1));
      byt = 1'($urandom_range(0, 1));
      a   = 16'($urandom_range(0, 511));
      if (!byt) a[0] = 1'b0;
      run_op(rd, byt, 1'($urandom_range(0, 1)), a, 16'($urandom),
             $urandom_range(0, 5), $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_cache_err();
    c_err = 1'b1;
    #1;
    tick();
    c_err = 1'b0;
    #1;
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL cache_err_set: got %b want 1", err);
    end
    tick();
    run_op(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 1, 0, "after_cerr");
    #1;
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL cache_err_sticky: got %b want 1", err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_out = 16'h0000;
    #1;
    vectors++;
    if (err !== 1'b0 || mem_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL cache_err_clear: got err=%b out=%h want 0 0000", err, mem_out);
    end
    tick();
  endtask

  task automatic test_timeout();
    int rd_cycles;
    bit dropped;
    rd_cycles = 0;
    dropped   = 1'b0;
    mem_read  = 1'b1;
    byte_op   = 1'b0;
    addr      = 16'h0070;
    c_done    = 1'b0;
    #1;
    tick();
    for (int n = 0; n < 20 && !dropped; n++) begin
      #1;
      if (c_rd === 1'b1) begin
        rd_cycles++;
      end else begin
        dropped = 1'b1;
        vectors++;
        if (dc_stall !== 1'b0 || mem_out !== model_out) begin
          miscompares++;
          $display("FAIL timeout_complete: got stall=%b out=%h want 0 %h",
                   dc_stall, mem_out, model_out);
        end
        mem_read = 1'b0;
      end
      tick();
    end
    mem_read = 1'b0;
    vectors++;
    if (!dropped || rd_cycles != 8) begin
      miscompares++;
      $display("FAIL timeout_len: got %0d request cycles (dropped=%b) want 8", rd_cycles, dropped);
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (err !== 1'b1 || c_rd !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout_err%0d: got err=%b rd=%b want 1 0", k, err, c_rd);
      end
      tick();
    end
    $display("op timeout a=0070 request_cycles=%0d", rd_cycles);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_out = 16'h0000;
    #1;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_clear: got %b want 0", err);
    end
    tick();
  endtask

  task automatic test_reset_mid_rmw();
    mem_write = 1'b1;
    byte_op   = 1'b1;
    addr      = 16'h0051;
    wdata     = 16'h0099;
    c_done    = 1'b0;
    #1;
    tick();
    #1;
    vectors++;
    if (c_rd !== 1'b1 || dc_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL rmw_rd_phase: got rd=%b stall=%b want 1 1", c_rd, dc_stall);
    end
    tick();
    rst       = 1'b1;
    mem_write = 1'b0;
    byte_op   = 1'b0;
    #1;
    vectors++;
    if (c_rd !== 1'b0 || c_wr !== 1'b0 || dc_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_rmw: got rd=%b wr=%b stall=%b want 0 0 0", c_rd, c_wr, dc_stall);
    end
    tick();
    rst = 1'b0;
    model_out = 16'h0000;
    #1;
    vectors++;
    if (c_rd !== 1'b0 || c_wr !== 1'b0 || dc_stall !== 1'b0 || mem_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL rst_mid_rmw_after: got rd=%b wr=%b stall=%b out=%h want 0 0 0 0000",
               c_rd, c_wr, dc_stall, mem_out);
    end
    tick();
    run_op(1'b1, 1'b0, 1'b0, 16'h0050, 16'h0000, 1, 0, "post_reset_load");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    opn         = 0;
    model_out   = 16'h0000;
    last_din    = 16'h0000;
    rst         = 1'b1;
    addr        = 16'h0000;
    wdata       = 16'h0000;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    byte_op     = 1'b0;
    sign_ext    = 1'b0;
    hold        = 1'b0;
    createdump  = 1'b0;
    c_dout      = 16'h0000;
    c_done      = 1'b0;
    c_stall     = 1'b0;
    c_err       = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    @(negedge clk);

    test_reset();
    test_word_load();
    test_byte_load();
    test_byte_store();
    test_misaligned();
    test_hold();
    test_back_to_back();
    test_random();
    test_cache_err();
    test_timeout();
    test_reset_mid_rmw();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got no finish want finish");
    $fatal(1, "time limit");
  end

endmodule
